// File: rtl/crc_job_scheduler.sv
// Two-requester CRC job scheduler: round-robin arbitration, credit-limited issue to a
// fixed-latency CRC datapath, and an in-order result FIFO.
module crc_job_scheduler #(
    parameter int PIPE_LAT   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_cs,
    input  logic        req0_ed,
    input  logic [71:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_cs,
    input  logic        req1_ed,
    input  logic [71:0] req1_data,
    output logic        core_cs,
    output logic        core_ed,
    output logic [71:0] core_data,
    input  logic [4:0]  core_crc5,
    input  logic [7:0]  core_crc8,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_id,
    output logic        res_cs,
    output logic        res_ed,
    output logic [7:0]  res_crc,
    output logic        res_error,
    output logic        busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = FIFO_DEPTH[CNT_W:0];

    typedef struct packed {
        logic vld;
        logic id;
        logic cs;
        logic ed;
    } tag_t;

    typedef struct packed {
        logic       id;
        logic       cs;
        logic       ed;
        logic [7:0] crc;
    } ent_t;

    tag_t             tag_q [PIPE_LAT];
    ent_t             mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             rr_ptr_q;

    logic        credit_ok;
    logic        gnt_id;
    logic        accept;
    logic        sel_cs;
    logic        sel_ed;
    logic [71:0] sel_data;
    tag_t        exit_tag;
    logic        push;
    logic        pop;
    logic [7:0]  push_crc;
    ent_t        head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit uses registered counts only, so a pop frees its slot one cycle later.
    assign credit_ok  = ({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_C;
    assign gnt_id     = (req0_valid & req1_valid) ? rr_ptr_q : req1_valid;
    assign accept     = (req0_valid | req1_valid) & credit_ok & ~rst;
    assign req0_ready = accept & ~gnt_id;
    assign req1_ready = accept & gnt_id;

    assign sel_cs   = gnt_id ? req1_cs   : req0_cs;
    assign sel_ed   = gnt_id ? req1_ed   : req0_ed;
    assign sel_data = gnt_id ? req1_data : req0_data;

    assign exit_tag = tag_q[PIPE_LAT-1];
    assign push     = exit_tag.vld;
    assign pop      = res_valid & res_ready;
    assign push_crc = exit_tag.cs ? core_crc8 : {3'b000, core_crc5};

    assign head      = mem_q[rd_ptr_q];
    assign res_valid = (count_q != '0);
    assign res_id    = head.id;
    assign res_cs    = head.cs;
    assign res_ed    = head.ed;
    assign res_crc   = head.crc;
    assign res_error = head.ed & (head.crc != 8'd0);
    assign busy      = (inflight_q != '0) | (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            core_cs    <= 1'b0;
            core_ed    <= 1'b0;
            core_data  <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rr_ptr_q   <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
        end else begin
            if (accept) begin
                core_cs   <= sel_cs;
                core_ed   <= sel_ed;
                core_data <= sel_data;
                rr_ptr_q  <= ~gnt_id;
            end
            // Idle cycles shift in a bubble so tag position always equals datapath age.
            tag_q[0] <= accept ? '{vld: 1'b1, id: gnt_id, cs: sel_cs, ed: sel_ed} : '0;
            for (int i = 1; i < PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];

            case ({accept, push})
                2'b10:   inflight_q <= inflight_q + CNT_W'(1);
                2'b01:   inflight_q <= inflight_q - CNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase

            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{id: exit_tag.id, cs: exit_tag.cs, ed: exit_tag.ed, crc: push_crc};
    end

endmodule
